mem_responder: RTL and testbench

Memory-side responder for the shared 16-bit data memory. Accepts single-word read, write and read-modify-add requests from an initiator (CPU load/store unit or a debug FSM) over a valid/ready handshake. Executes each request against an internal dual-port block RAM and returns one response per request, held until accepted. The second RAM port is a read-only debug tap that drives board displays.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_responder_dp_bram.sv | 21 ++
 rtl/mem_responder.sv | 86 ++++++++
 tb/tb_mem_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared op/state encodings and default sizes for the data-memory responder.
package mem_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_MEM_DEPTH = 1024;
  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_ADD   = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;
  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    MODIFY,
    RESP
  } state_t;
endpackage

// File: rtl/mem_responder_dp_bram.sv
// dp_bram: read-first dual-port synchronous RAM; port A read/write, port B read-only.
module dp_bram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_a,
  input  logic [AW-1:0]         addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]         addr_b,
  output logic [DATA_WIDTH-1:0] rdata_b
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wdata_a;
    rdata_a <= mem[addr_a];
  end
  always_ff @(posedge clk) rdata_b <= mem[addr_b];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: valid/ready single-word read/write/add responder over a dual-port block RAM.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_rdata
);
  localparam int AW = $clog2(MEM_DEPTH);
  state_t state, state_n;
  op_t op_q;
  logic [AW-1:0] addr_q, ram_addr;
  logic [DATA_WIDTH-1:0] wdata_q, ram_wdata, ram_rdata;
  logic ram_we, accept, err;
  logic unused_dbg;
  assign unused_dbg = ^dbg_addr[ADDR_WIDTH-1:AW];
  assign accept = req_valid & req_ready;
  assign err = (32'(req_addr) >= MEM_DEPTH) | (req_op == OP_RSVD);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:          if (accept) state_n = err ? RESP : (req_op == OP_WRITE) ? WRITE : READ;
      READ:          state_n = (op_q == OP_ADD) ? MODIFY : RESP;
      WRITE, MODIFY: state_n = RESP;
      RESP:          if (rsp_ready) state_n = IDLE;
      default:       state_n = IDLE;
    endcase
  end
  // Port A follows the live request address while idle so the old word is ready one edge after accept.
  always_comb begin
    req_ready = (state == IDLE) & ~reset;
    rsp_valid = state == RESP;
    ram_we = ((state == WRITE) | (state == MODIFY)) & ~reset;
    ram_addr = (state == IDLE) ? req_addr[AW-1:0] : addr_q;
    ram_wdata = (state == MODIFY) ? rsp_data + wdata_q : wdata_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= OP_READ;
      addr_q <= '0;
      wdata_q <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else if (accept) begin
      op_q <= op_t'(req_op);
      addr_q <= req_addr[AW-1:0];
      wdata_q <= req_wdata;
      rsp_data <= '0;
      rsp_err <= err;
    end else if (state == READ) begin
      rsp_data <= ram_rdata;
    end else if (state == WRITE) begin
      rsp_data <= wdata_q;
    end
  end
  dp_bram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH(MEM_DEPTH)
  ) u_ram (
    .clk(clk),
    .we_a(ram_we),
    .addr_a(ram_addr),
    .wdata_a(ram_wdata),
    .rdata_a(ram_rdata),
    .addr_b(dbg_addr[AW-1:0]),
    .rdata_b(dbg_rdata)
  );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scenario tasks plus randomized traffic checked against a word-array memory model.
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [1:0] req_op = 2'b00;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic rsp_err;
  logic [15:0] dbg_addr = '0;
  logic [15:0] dbg_rdata;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic [15:0] model_mem [1024];

  mem_responder dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Expected response: data, err, and the edge (counting the accept edge as 1) at which rsp_valid is first sampled high.
  function automatic void model_apply(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] w,
                                      output logic [15:0] d, output logic e, output int ed);
    if (op == 2'b11 || addr >= 16'd1024) begin
      d = 16'h0; e = 1'b1; ed = 1;
    end else begin
      e = 1'b0; d = model_mem[addr[9:0]]; ed = 2;
      if (op == 2'b01) begin
        model_mem[addr[9:0]] = w; d = w;
      end else if (op == 2'b10) begin
        model_mem[addr[9:0]] = d + w; ed = 3;
      end
    end
  endfunction

  // Drives one request as soon as the responder is ready and returns once rsp_valid is seen.
  task automatic xact(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] w,
                      output logic [15:0] d, output logic e, output int ed, output int acc);
    int n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = w;
    @(posedge clk); #1;
    acc = cyc;
    req_valid = 1'b0; req_op = 2'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
    ed = 1;
    while (!rsp_valid && ed < 20) begin @(posedge clk); #1; ed++; end
    d = rsp_data; e = rsp_err;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 16'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0000", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_write_read();
    logic [15:0] d, xd; logic e, xe; int ed, xed, acc;
    model_apply(2'b01, 16'd5, 16'h1234, xd, xe, xed);
    xact(2'b01, 16'd5, 16'h1234, d, e, ed, acc);
    checks++; if (d !== 16'h1234 || e !== 1'b0) begin failures++; $display("FAIL write5 got=%h/%b exp=1234/0", d, e); end
    checks++; if (ed !== 2) begin failures++; $display("FAIL write5_latency got=%0d exp=2", ed); end
    model_apply(2'b00, 16'd5, 16'h0, xd, xe, xed);
    xact(2'b00, 16'd5, 16'h0, d, e, ed, acc);
    checks++; if (d !== 16'h1234 || e !== 1'b0) begin failures++; $display("FAIL read5 got=%h/%b exp=1234/0", d, e); end
    checks++; if (ed !== 2) begin failures++; $display("FAIL read5_latency got=%0d exp=2", ed); end
  endtask

  task automatic test_add();
    logic [15:0] d, xd; logic e, xe; int ed, xed, acc;
    model_apply(2'b01, 16'd7, 16'h0010, xd, xe, xed);
    xact(2'b01, 16'd7, 16'h0010, d, e, ed, acc);
    model_apply(2'b10, 16'd7, 16'h0002, xd, xe, xed);
    xact(2'b10, 16'd7, 16'h0002, d, e, ed, acc);
    checks++; if (d !== 16'h0010 || e !== 1'b0) begin failures++; $display("FAIL add7_old got=%h/%b exp=0010/0", d, e); end
    checks++; if (ed !== 3) begin failures++; $display("FAIL add7_latency got=%0d exp=3", ed); end
    model_apply(2'b00, 16'd7, 16'h0, xd, xe, xed);
    xact(2'b00, 16'd7, 16'h0, d, e, ed, acc);
    checks++; if (d !== 16'h0012) begin failures++; $display("FAIL add7_sum got=%h exp=0012", d); end
    model_apply(2'b01, 16'd8, 16'hFFFF, xd, xe, xed);
    xact(2'b01, 16'd8, 16'hFFFF, d, e, ed, acc);
    model_apply(2'b10, 16'd8, 16'h0002, xd, xe, xed);
    xact(2'b10, 16'd8, 16'h0002, d, e, ed, acc);
    checks++; if (d !== 16'hFFFF) begin failures++; $display("FAIL add8_old got=%h exp=ffff", d); end
    model_apply(2'b00, 16'd8, 16'h0, xd, xe, xed);
    xact(2'b00, 16'd8, 16'h0, d, e, ed, acc);
    checks++; if (d !== 16'h0001) begin failures++; $display("FAIL add8_wrap got=%h exp=0001", d); end
  endtask

  task automatic test_error();
    logic [15:0] d, xd; logic e, xe; int ed, xed, acc;
    model_apply(2'b01, 16'd976, 16'h5A5A, xd, xe, xed);
    xact(2'b01, 16'd976, 16'h5A5A, d, e, ed, acc);
    xact(2'b00, 16'd1024, 16'h0, d, e, ed, acc);
    checks++; if (d !== 16'h0 || e !== 1'b1) begin failures++; $display("FAIL err_addr1024 got=%h/%b exp=0000/1", d, e); end
    checks++; if (ed !== 1) begin failures++; $display("FAIL err_latency got=%0d exp=1", ed); end
    xact(2'b01, 16'd2000, 16'hDEAD, d, e, ed, acc);
    checks++; if (d !== 16'h0 || e !== 1'b1) begin failures++; $display("FAIL err_write2000 got=%h/%b exp=0000/1", d, e); end
    xact(2'b11, 16'd5, 16'hDEAD, d, e, ed, acc);
    checks++; if (d !== 16'h0 || e !== 1'b1 || ed !== 1) begin failures++; $display("FAIL err_op11 got=%h/%b/%0d exp=0000/1/1", d, e, ed); end
    model_apply(2'b00, 16'd976, 16'h0, xd, xe, xed);
    xact(2'b00, 16'd976, 16'h0, d, e, ed, acc);
    checks++; if (d !== xd) begin failures++; $display("FAIL err_no_alias got=%h exp=%h", d, xd); end
    model_apply(2'b00, 16'd5, 16'h0, xd, xe, xed);
    xact(2'b00, 16'd5, 16'h0, d, e, ed, acc);
    checks++; if (d !== xd) begin failures++; $display("FAIL err_op11_no_write got=%h exp=%h", d, xd); end
  endtask

  task automatic test_backpressure();
    logic [15:0] d, xd; logic e, xe; int ed, xed, acc;
    model_apply(2'b00, 16'd5, 16'h0, xd, xe, xed);
    rsp_ready = 1'b0;
    xact(2'b00, 16'd5, 16'h0, d, e, ed, acc);
    for (int i = 0; i < 5; i++) begin
      req_valid = (i % 2) == 0; req_op = 2'b01; req_addr = 16'd5; req_wdata = 16'hDEAD;
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== xd || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        failures++; $display("FAIL stall_%0d got v=%b d=%h e=%b rdy=%b exp v=1 d=%h e=0 rdy=0", i, rsp_valid, rsp_data, rsp_err, req_ready, xd);
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL stall_release got v=%b rdy=%b exp v=0 rdy=1", rsp_valid, req_ready); end
    xact(2'b00, 16'd5, 16'h0, d, e, ed, acc);
    checks++; if (d !== xd) begin failures++; $display("FAIL stall_no_write got=%h exp=%h", d, xd); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d, xd; logic e, xe; int ed, xed, a0, a1, a2;
    model_apply(2'b00, 16'd7, 16'h0, xd, xe, xed);
    xact(2'b00, 16'd7, 16'h0, d, e, ed, a0);
    model_apply(2'b10, 16'd7, 16'h0003, xd, xe, xed);
    xact(2'b10, 16'd7, 16'h0003, d, e, ed, a1);
    model_apply(2'b00, 16'd7, 16'h0, xd, xe, xed);
    xact(2'b00, 16'd7, 16'h0, d, e, ed, a2);
    checks++; if (a1 - a0 !== 3) begin failures++; $display("FAIL b2b_read_spacing got=%0d exp=3", a1 - a0); end
    checks++; if (a2 - a1 !== 4) begin failures++; $display("FAIL b2b_add_spacing got=%0d exp=4", a2 - a1); end
    checks++; if (d !== xd) begin failures++; $display("FAIL b2b_data got=%h exp=%h", d, xd); end
  endtask

  task automatic test_debug();
    logic [15:0] d, xd; logic e, xe; int ed, xed, acc;
    model_apply(2'b01, 16'd3, 16'h0A0A, xd, xe, xed);
    xact(2'b01, 16'd3, 16'h0A0A, d, e, ed, acc);
    wait_ready();
    dbg_addr = 16'd3;
    req_valid = 1'b1; req_op = 2'b01; req_addr = 16'd3; req_wdata = 16'hBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (dbg_rdata !== 16'h0A0A) begin failures++; $display("FAIL dbg_read_first got=%h exp=0a0a", dbg_rdata); end
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF) begin failures++; $display("FAIL dbg_write_rsp got=%b/%h exp=1/beef", rsp_valid, rsp_data); end
    @(posedge clk); #1;
    checks++; if (dbg_rdata !== 16'hBEEF) begin failures++; $display("FAIL dbg_new got=%h exp=beef", dbg_rdata); end
    model_apply(2'b01, 16'd3, 16'hBEEF, xd, xe, xed);
  endtask

  task automatic test_reset_mid_add();
    logic [15:0] d, xd; logic e, xe; int ed, xed, acc;
    model_apply(2'b01, 16'd9, 16'h0004, xd, xe, xed);
    xact(2'b01, 16'd9, 16'h0004, d, e, ed, acc);
    wait_ready();
    req_valid = 1'b1; req_op = 2'b10; req_addr = 16'd9; req_wdata = 16'h0005;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 16'h0 || rsp_err !== 1'b0) begin
      failures++; $display("FAIL mid_add_reset got rdy=%b v=%b d=%h e=%b exp 0/0/0000/0", req_ready, rsp_valid, rsp_data, rsp_err);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_apply(2'b00, 16'd9, 16'h0, xd, xe, xed);
    xact(2'b00, 16'd9, 16'h0, d, e, ed, acc);
    checks++; if (d !== 16'h0004 || e !== 1'b0 || ed !== 2) begin failures++; $display("FAIL mid_add_mem9 got=%h/%b/%0d exp=0004/0/2", d, e, ed); end
  endtask

  task automatic test_random();
    logic [15:0] d, xd, a, w; logic e, xe; logic [1:0] op; int ed, xed, acc;
    for (int i = 0; i < 16; i++) begin
      w = 16'($urandom);
      model_apply(2'b01, 16'(i), w, xd, xe, xed);
      xact(2'b01, 16'(i), w, d, e, ed, acc);
    end
    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(1024, 65535)) : 16'($urandom_range(0, 15));
      w = 16'($urandom);
      model_apply(op, a, w, xd, xe, xed);
      xact(op, a, w, d, e, ed, acc);
      checks++;
      if (d !== xd || e !== xe || ed !== xed) begin
        failures++; $display("FAIL rand_%0d op=%0d addr=%h got=%h/%b/%0d exp=%h/%b/%0d", i, op, a, d, e, ed, xd, xe, xed);
      end
      dbg_addr = 16'($urandom_range(0, 15));
      @(posedge clk); #1;
      checks++;
      if (dbg_rdata !== model_mem[dbg_addr[9:0]]) begin
        failures++; $display("FAIL rand_dbg_%0d addr=%0d got=%h exp=%h", i, dbg_addr, dbg_rdata, model_mem[dbg_addr[9:0]]);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_add();
    test_error();
    test_backpressure();
    test_back_to_back();
    test_debug();
    test_reset_mid_add();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
